// File: rtl/nibble_serial_subtractor16.sv
// 16-bit subtractor that processes one nibble per clock, least-significant nibble first.
// Results are published only when a full operation completes.
module nibble_serial_subtractor16 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [0:15] A,
   input  logic [0:15] B,
   input  logic        bin,
   output logic [0:15] D,
   output logic        bout,
   output logic        ovf,
   output logic        zero,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [0:15] a_q, a_d;
   logic [0:15] b_q, b_d;
   logic        borrow_q, borrow_d;
   logic [0:15] part_q, part_d;
   logic [0:15] d_q, d_d;
   logic        bout_q, bout_d;
   logic        ovf_q, ovf_d;
   logic        zero_q, zero_d;

   logic [3:0]  nib_base;
   logic [3:0]  a_nib;
   logic [3:0]  b_nib;
   logic [4:0]  diff;
   logic [0:15] res_full;

   // Bit 0 is the MSB, so nibble 0 (least significant) lives at [12:15].
   always_comb begin
      nib_base = 4'd12 - {cnt_q, 2'b00};
      a_nib    = a_q[nib_base +: 4];
      b_nib    = b_q[nib_base +: 4];
      diff     = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};
      res_full = part_q;
      res_full[nib_base +: 4] = diff[3:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      part_d   = part_q;
      d_d      = d_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = A;
               b_d      = B;
               borrow_d = bin;
               cnt_d    = 2'd0;
               part_d   = 16'h0000;
               state_d  = RUN;
            end
         end
         RUN: begin
            part_d   = res_full;
            borrow_d = diff[4];
            if (cnt_q == 2'd3) begin
               // Final nibble: publish the complete result in one step.
               d_d     = res_full;
               bout_d  = diff[4];
               ovf_d   = (a_q[0] != b_q[0]) && (res_full[0] != a_q[0]);
               zero_d  = (res_full == 16'h0000);
               cnt_d   = 2'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         borrow_q <= 1'b0;
         part_q   <= 16'h0000;
         d_q      <= 16'h0000;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         part_q   <= part_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign D         = d_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_nibble_serial_subtractor16.sv
// Directed bench for nibble_serial_subtractor16: expected results are queued at issue
// time and a negedge monitor pops and compares each time done is seen.
module tb_nibble_serial_subtractor16;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [0:15] A;
   logic [0:15] B;
   logic        bin;
   logic [0:15] D;
   logic        bout;
   logic        ovf;
   logic        zero;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   int vectors;
   int miscompares;
   int cyc;
   logic [18:0] exp_q[$];

   nibble_serial_subtractor16 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .A         (A),
      .B         (B),
      .bin       (bin),
      .D         (D),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset_n && done === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: got result %h expected no done", {D, bout, ovf, zero});
         end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            if ({D, bout, ovf, zero} !== e) begin
               miscompares++;
               $display("FAIL result: got D=%h bout=%b ovf=%b zero=%b expected D=%h bout=%b ovf=%b zero=%b",
                        D, bout, ovf, zero, e[18:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   // driver: one operation, checks busy/done timing cycle by cycle and result hold afterwards
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input logic [15:0] ed, input logic eb, input logic eo, input logic ez,
                         input logic disturb);
      exp_q.push_back({ed, eb, eo, ez});
      @(negedge clk);
      A = a; B = b; bin = bi; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("busy_c%0d", i), {31'b0, busy}, {31'b0, (i <= 4)});
         check($sformatf("done_c%0d", i), {31'b0, done}, {31'b0, (i == 5)});
         if (disturb && i == 1) begin
            A = 16'hFFFF; B = 16'hFFFF; bin = 1'b1; start = 1'b1;
         end
         if (disturb && i == 3) start = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("hold_D", {16'b0, D}, {16'b0, ed});
      check("hold_flags", {29'b0, bout, ovf, zero}, {29'b0, eb, eo, ez});
      check("idle_done", {31'b0, done}, 32'd0);
   endtask

   initial begin
      int t[3];
      int waited;
      vectors = 0; miscompares = 0; cyc = 0;
      start = 1'b0; A = 16'h0000; B = 16'h0000; bin = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_D", {16'b0, D}, 32'd0);
      check("rst_flags", {26'b0, bout, ovf, zero, busy, done, 1'b0}, 32'd0);
      check("rst_state", {30'b0, state_dbg}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op(16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op(16'h1234, 16'h0FFF, 1'b1, 16'h0234, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
      // operands and start disturbed during RUN: one done, original operands
      run_op(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (8) @(negedge clk);

      // start held high: one result every 6 cycles
      A = 16'h0010; B = 16'h0001; bin = 1'b0;
      for (int k = 0; k < 3; k++) exp_q.push_back({16'h000F, 1'b0, 1'b0, 1'b0});
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (done !== 1'b1 && waited < 20);
         if (k == 2) start = 1'b0;
         t[k] = cyc;
         check($sformatf("held_done_seen%0d", k), {31'b0, done}, 32'd1);
      end
      check("period_0_1", t[1] - t[0], 32'd6);
      check("period_1_2", t[2] - t[1], 32'd6);
      repeat (8) @(negedge clk);

      // reset mid-operation: no done, outputs cleared at once
      @(negedge clk);
      A = 16'hFFFF; B = 16'h0000; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_D", {16'b0, D}, 32'd0);
      check("abort_flags", {27'b0, bout, ovf, zero, busy, done}, 32'd0);
      repeat (3) @(negedge clk);
      check("abort_state", {30'b0, state_dbg}, 32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_result", {16'b0, D}, 32'd0);

      run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
